// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and default sizes for the boot loader
package imem_loader_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int MAX_WORDS_DEF = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// imem_loader_packer: big-endian byte-to-word assembler with running XOR checksum
module imem_loader_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last,
    output logic [7:0]  acc
);
    logic [23:0] sr;
    logic [1:0]  idx;

    assign word = {sr, byte_in};
    assign last = idx == 2'd3;

    // Shift accepted bytes in MSB first; the word is complete when the 4th byte is on byte_in
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sr  <= '0;
            idx <= '0;
            acc <= '0;
        end else if (shift) begin
            sr  <= {sr[15:0], byte_in};
            idx <= idx + 2'd1;
            acc <= acc ^ byte_in;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a [N][payload][XOR] byte stream into instruction memory while holding the CPU
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [6:0]        words_out
);
    state_t      state;
    logic [6:0]  n;
    logic        xfer;
    logic        shift;
    logic        clr;
    logic        last;
    logic [31:0] word;
    logic [7:0]  acc;

    assign xfer  = byte_valid && byte_ready;
    assign shift = xfer && state == DATA;
    assign clr   = start && (state == IDLE || state == DONE || state == ERR);

    imem_loader_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .shift   (shift),
        .byte_in (byte_in),
        .word    (word),
        .last    (last),
        .acc     (acc)
    );

    // Load sequencer; the write register is separate from the packer so bytes keep flowing during a write
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            n          <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_out  <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state      <= HDR;
                    byte_ready <= 1'b1;
                    cpu_hold   <= 1'b1;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    words_out  <= '0;
                    waddr      <= '0;
                end
                HDR: if (xfer) begin
                    if (byte_in == 8'd0) begin
                        state <= CHK;
                    end else if (byte_in > 8'(MAX_WORDS)) begin
                        state      <= ERR;
                        err        <= 1'b1;
                        cpu_hold   <= 1'b0;
                        byte_ready <= 1'b0;
                    end else begin
                        n     <= byte_in[6:0];
                        state <= DATA;
                    end
                end
                DATA: if (shift && last) begin
                    we        <= 1'b1;
                    wdata     <= word;
                    waddr     <= ADDR_W'({words_out, 2'b00});
                    words_out <= words_out + 7'd1;
                    state     <= (words_out + 7'd1 == n) ? CHK : DATA;
                end
                CHK: if (xfer) begin
                    state      <= (byte_in == acc) ? DONE : ERR;
                    done       <= byte_in == acc;
                    err        <= byte_in != acc;
                    cpu_hold   <= 1'b0;
                    byte_ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven stream vectors plus directed multi-cycle corner cases
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [6:0]  words_out;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] wo_q[$];

    typedef struct {
        string           name;
        int              len;
        logic [0:15][7:0] b;
        bit              gap;
        logic            dn;
        logic            er;
        int              words;
        logic [2:0][31:0] wd;
    } vec_t;

    vec_t tbl[8];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .words_out  (words_out)
    );

    always #5 clk = ~clk;

    // log every imem write, sampled mid-cycle
    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(32'(waddr));
            wd_q.push_back(wdata);
            wo_q.push_back(32'(words_out));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input bit gap, input logic dn, input logic er,
                                input int words, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [7:0] s[$]);
        vec_t v;
        v.name  = nm;
        v.len   = s.size();
        v.b     = '0;
        for (int i = 0; i < s.size(); i++) v.b[i] = s[i];
        v.gap   = gap;
        v.dn    = dn;
        v.er    = er;
        v.words = words;
        v.wd[0] = w0;
        v.wd[1] = w1;
        v.wd[2] = w2;
        return v;
    endfunction

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wo_q.delete();
        stalls = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k;
        @(negedge clk);
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_in    = b;
        k = 0;
        while (!byte_ready && k < 20) begin
            stalls++;
            @(negedge clk);
            k++;
        end
        if (k == 20) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %h not accepted within 20 cycles", b);
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_end(input vec_t v);
        @(negedge clk);
        chk({v.name, "_done"}, 32'(done), 32'(v.dn));
        chk({v.name, "_err"}, 32'(err), 32'(v.er));
        chk({v.name, "_words"}, 32'(words_out), 32'(v.words));
        chk({v.name, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({v.name, "_ready"}, 32'(byte_ready), 32'd0);
        chk({v.name, "_nwrites"}, 32'(wa_q.size()), 32'(v.words));
        for (int i = 0; i < v.words && i < wa_q.size(); i++) begin
            chk($sformatf("%s_waddr%0d", v.name, i), wa_q[i], 32'(4 * i));
            chk($sformatf("%s_wdata%0d", v.name, i), wd_q[i], v.wd[i]);
            chk($sformatf("%s_wcount%0d", v.name, i), wo_q[i], 32'(i + 1));
        end
        chk({v.name, "_stalls"}, 32'(stalls), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit mid_start);
        clear_log();
        pulse_start();
        chk({v.name, "_hold_on"}, 32'(cpu_hold), 32'd1);
        chk({v.name, "_ready_on"}, 32'(byte_ready), 32'd1);
        for (int i = 0; i < v.len; i++) begin
            send_byte(v.b[i], v.gap);
            if (mid_start && i == 2) pulse_start();
        end
        check_end(v);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_words"}, 32'(words_out), 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        tbl[0] = mk("n2_good", 0, 1, 0, 2, 32'h20080005, 32'h8C090000, 32'h0,
                    '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00, 8'hA8});
        tbl[1] = mk("n2_badchk", 0, 0, 1, 2, 32'h20080005, 32'h8C090000, 32'h0,
                    '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00, 8'h00});
        tbl[2] = mk("n65", 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, '{8'h41});
        tbl[3] = mk("nff", 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, '{8'hFF});
        tbl[4] = mk("n0_good", 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, '{8'h00, 8'h00});
        tbl[5] = mk("n0_bad", 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, '{8'h00, 8'h01});
        tbl[6] = mk("n3_b2b", 0, 1, 0, 3, 32'h11223344, 32'h55667788, 32'hDEADBEEF,
                    '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                      8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAA});
        tbl[7] = mk("n3_gaps", 1, 1, 0, 3, 32'h11223344, 32'h55667788, 32'hDEADBEEF,
                    '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                      8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAA});

        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(tbl[k], 1'b0);

        // start during a load must be ignored
        run_vec(tbl[0], 1'b1);

        // reset after 5 payload bytes
        clear_log();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h8C, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        reset = 1'b0;

        // start with byte_valid in IDLE: the 0x41 must not be taken as a header
        clear_log();
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h41;
        chk("sv_ready_idle", 32'(byte_ready), 32'd0);
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_end(tbl[4]);

        // clean reload after the aborted one
        run_vec(tbl[0], 1'b0);

        // maximum length N=64, payload 00..FF, XOR of 00..FF is 00
        clear_log();
        pulse_start();
        send_byte(8'h40, 1'b0);
        for (int i = 0; i < 256; i++) send_byte(i[7:0], 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        chk("max_done", 32'(done), 32'd1);
        chk("max_err", 32'(err), 32'd0);
        chk("max_words", 32'(words_out), 32'd64);
        chk("max_nwrites", 32'(wa_q.size()), 32'd64);
        chk("max_stalls", 32'(stalls), 32'd0);
        for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
            a = 8'(4 * i);
            chk($sformatf("max_waddr%0d", i), wa_q[i], 32'(4 * i));
            chk($sformatf("max_wdata%0d", i), wd_q[i], {a, a + 8'd1, a + 8'd2, a + 8'd3});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
